// File: rtl/operand_pair_stager.sv
// operand_pair_stager
//
// Buffers a serial stream of INPUT_WIDTH-bit words in a DEPTH-entry circular FIFO
// and presents them as ordered operand pairs: in0 is the older word, in1 the newer.
// A pair is popped atomically, so a lone word waits until its partner arrives.
//
// Ports:
//   clock      - single clock, rising-edge state updates
//   reset      - asynchronous, active-low reset of pointers and count
//   flush      - synchronous clear of all buffered words (priority over push/pop)
//   in_data    - incoming word
//   in_valid   - in_data is valid
//   in_ready   - stage can accept a word this cycle (depends on registered state only)
//   in0, in1   - older / newer word of the head pair, zero when out_valid is low
//   out_valid  - a pair is available on in0/in1
//   out_ready  - downstream consumes the pair this cycle
//   level      - number of words currently buffered
module operand_pair_stager #(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [INPUT_WIDTH-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [INPUT_WIDTH-1:0]   in0,
    output logic [INPUT_WIDTH-1:0]   in1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [INPUT_WIDTH-1:0] mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            push;
    logic            pop;
    logic [PtrW-1:0] rd_ptr_nxt;
    logic [CntW-1:0] inc;
    logic [CntW-1:0] dec;

    // Handshakes come from registered count only.
    assign in_ready  = (count_q < CntW'(DEPTH));
    assign out_valid = (count_q >= CntW'(2));
    assign level     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

    assign in0 = out_valid ? mem_q[rd_ptr_q]   : '0;
    assign in1 = out_valid ? mem_q[rd_ptr_nxt] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        inc      = push ? CntW'(1) : '0;
        dec      = pop  ? CntW'(2) : '0;
        count_d  = count_q + inc - dec;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(2);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a flushed push must not write.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_operand_pair_stager.sv
module tb_operand_pair_stager;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset;
    logic          flush;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in0;
    logic [W-1:0]  in1;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;

    operand_pair_stager #(
        .INPUT_WIDTH(W),
        .DEPTH      (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in0      (in0),
        .in1      (in1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level    (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: buffered words in arrival order.
    logic [W-1:0] q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_pairs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] e0, e1;
        bit           ev;
        ev = (q.size() >= 2);
        e0 = ev ? q[0] : '0;
        e1 = ev ? q[1] : '0;
        check({tag, ".level"},     32'(level),     32'(q.size()));
        check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".in0"},       32'(in0),       32'(e0));
        check({tag, ".in1"},       32'(in1),       32'(e1));
    endtask

    // Called at a negedge: drive, update model with this cycle's handshake, sample next negedge.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                         input logic r, input logic f);
        bit push, pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        push = v && (q.size() < DEPTH);
        pop  = r && (q.size() >= 2);
        if (f) begin
            q.delete();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                void'(q.pop_front());
                n_pairs++;
            end
            if (push) q.push_back(d);
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] w;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        check_outputs("in_reset");
        @(negedge clock);
        reset = 1'b1;
        check_outputs("post_reset");

        // Ordered pairs with out_ready high.
        cycle("ord", 1'b1, 8'h11, 1'b1, 1'b0);
        check("ord.no_pair_yet", 32'(out_valid), 32'd0);
        cycle("ord", 1'b1, 8'h22, 1'b1, 1'b0);
        check("ord.pair0_in0", 32'(in0), 32'h11);
        check("ord.pair0_in1", 32'(in1), 32'h22);
        cycle("ord", 1'b1, 8'h33, 1'b1, 1'b0);
        cycle("ord", 1'b1, 8'h44, 1'b0, 1'b0);
        check("ord.pair1_in0", 32'(in0), 32'h33);
        check("ord.pair1_in1", 32'(in1), 32'h44);
        cycle("ord", 1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure to full.
        for (int i = 0; i < 5; i++) cycle("bp", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        check("bp.full_level", 32'(level), 32'(DEPTH));
        check("bp.full_ready", 32'(in_ready), 32'd0);
        cycle("bp_pop", 1'b1, 8'hA4, 1'b1, 1'b0);
        check("bp.ready_back", 32'(in_ready), 32'd1);
        cycle("bp_acc", 1'b1, 8'hA4, 1'b0, 1'b0);
        check("bp.after_level", 32'(level), 32'd3);
        cycle("bp_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("bp_flush", 1'b0, 8'h00, 1'b0, 1'b1);

        // Wrap: push 3, pop 1 pair, push 3 more.
        for (int i = 0; i < 3; i++) cycle("wrap", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 3; i < 6; i++) cycle("wrap", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        check("wrap.in0", 32'(in0), 32'hC2);
        check("wrap.in1", 32'(in1), 32'hC3);
        cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap.in0b", 32'(in0), 32'hC4);
        check("wrap.in1b", 32'(in1), 32'hC5);
        cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Odd word hold.
        cycle("odd", 1'b1, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("odd_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("odd", 1'b1, 8'h5B, 1'b0, 1'b0);
        check("odd.in0", 32'(in0), 32'h5A);
        check("odd.in1", 32'(in1), 32'h5B);
        cycle("odd_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with simultaneous handshake at level 3.
        for (int i = 0; i < 3; i++) cycle("fl", 1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
        cycle("fl_hit", 1'b1, 8'hEE, 1'b1, 1'b1);
        check("fl.level0", 32'(level), 32'd0);
        cycle("fl", 1'b1, 8'h01, 1'b0, 1'b0);
        cycle("fl", 1'b1, 8'h02, 1'b0, 1'b0);
        check("fl.in0", 32'(in0), 32'h01);
        check("fl.in1", 32'(in1), 32'h02);

        // Reset mid-operation at level 2.
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        check_outputs("rst_mid");
        @(negedge clock);
        reset = 1'b1;
        check_outputs("rst_rel");
        cycle("rst_after", 1'b1, 8'h71, 1'b0, 1'b0);
        cycle("rst_after", 1'b1, 8'h72, 1'b1, 1'b0);
        check("rst.in0", 32'(in0), 32'h71);
        cycle("rst_after", 1'b0, 8'h00, 1'b1, 1'b0);

        // Sustained full rate.
        for (int i = 0; i < 40; i++) cycle("rate", 1'b1, 8'($urandom), 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            w = 8'($urandom);
            cycle("rand", 1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 49) == 0));
        end

        check("pairs_seen", 32'(n_pairs > 100), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
